// File: rtl/memory_access.sv
// rtl/memory_access.sv - MIPS MEM stage: byte-addressed data memory with sub-word access and MEM/WB register
module memory_access #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_stall,
    input  logic               i_halt,
    input  logic [NB_DATA-1:0] i_result,
    input  logic [NB_DATA-1:0] i_data2mem,
    input  logic [4:0]         i_write_reg,
    input  logic               i_mem2reg,
    input  logic               i_memRead,
    input  logic               i_memWrite,
    input  logic               i_regWrite,
    input  logic [1:0]         i_width,
    input  logic               i_unsigned,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
    output logic [NB_DATA-1:0] o_dbg_data,
    output logic [NB_DATA-1:0] o_read_data,
    output logic [NB_DATA-1:0] o_result,
    output logic [4:0]         o_write_reg,
    output logic               o_mem2reg,
    output logic               o_regWrite,
    output logic               o_misaligned
);
    localparam int DEPTH = 2**NB_ADDR;

    logic [NB_DATA-1:0] mem [DEPTH];
    logic [NB_ADDR-1:0] word_idx;
    logic [1:0]         lane;
    logic               hold;
    logic               misaligned;
    logic               wr_en;
    logic [3:0]         wr_mask;
    logic [NB_DATA-1:0] wr_data;
    logic [NB_DATA-1:0] old_word;
    logic [NB_DATA-1:0] load_data;
    logic [7:0]         sel_byte;
    logic [15:0]        sel_half;
    logic               unused_bits;

    // Upper address bits are deliberately dropped so accesses wrap around the array.
    assign word_idx    = i_result[NB_ADDR+1:2];
    assign lane        = i_result[1:0];
    assign unused_bits = ^i_result[NB_DATA-1:NB_ADDR+2];

    assign hold     = i_stall | i_halt;
    assign old_word = mem[word_idx];
    assign sel_byte = old_word[{lane, 3'b000} +: 8];
    assign sel_half = lane[1] ? old_word[31:16] : old_word[15:0];
    assign wr_en    = i_memWrite & ~misaligned & ~hold;

    always_comb begin
        misaligned = 1'b0;
        wr_mask    = 4'b1111;
        wr_data    = i_data2mem;
        load_data  = '0;
        case (i_width)
            2'b00: begin
                wr_mask = 4'b0001 << lane;
                wr_data = {4{i_data2mem[7:0]}};
                load_data = {{24{sel_byte[7] & ~i_unsigned}}, sel_byte};
            end
            2'b01: begin
                misaligned = lane[0];
                wr_mask = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{i_data2mem[15:0]}};
                load_data = {{16{sel_half[15] & ~i_unsigned}}, sel_half};
            end
            default: begin
                misaligned = (lane != 2'b00);
                load_data = old_word;
            end
        endcase
        // Only memory instructions can be misaligned; ALU results pass through untouched.
        misaligned = misaligned & (i_memRead | i_memWrite);
        if (!i_memRead || misaligned)
            load_data = '0;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < 4; k++)
                if (wr_mask[k])
                    mem[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
        end
    end

    assign o_dbg_data = mem[i_dbg_addr];

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_read_data  <= '0;
            o_result     <= '0;
            o_write_reg  <= '0;
            o_mem2reg    <= 1'b0;
            o_regWrite   <= 1'b0;
            o_misaligned <= 1'b0;
        end else if (!hold) begin
            o_read_data  <= load_data;
            o_result     <= i_result;
            o_write_reg  <= i_write_reg;
            o_mem2reg    <= i_mem2reg;
            o_regWrite   <= i_regWrite;
            o_misaligned <= misaligned;
        end
    end
endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - directed vector table plus randomized reference-model check of memory_access
module tb_memory_access;
    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_stall, i_halt;
    logic [31:0] i_result, i_data2mem;
    logic [4:0]  i_write_reg;
    logic        i_mem2reg, i_memRead, i_memWrite, i_regWrite;
    logic [1:0]  i_width;
    logic        i_unsigned;
    logic [7:0]  i_dbg_addr;
    logic [31:0] o_dbg_data, o_read_data, o_result;
    logic [4:0]  o_write_reg;
    logic        o_mem2reg, o_regWrite, o_misaligned;

    int n_cmp = 0;
    int n_bad = 0;

    memory_access #(.NB_DATA(32), .NB_ADDR(8)) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_stall(i_stall), .i_halt(i_halt),
        .i_result(i_result), .i_data2mem(i_data2mem), .i_write_reg(i_write_reg),
        .i_mem2reg(i_mem2reg), .i_memRead(i_memRead), .i_memWrite(i_memWrite),
        .i_regWrite(i_regWrite), .i_width(i_width), .i_unsigned(i_unsigned),
        .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data), .o_read_data(o_read_data),
        .o_result(o_result), .o_write_reg(o_write_reg), .o_mem2reg(o_mem2reg),
        .o_regWrite(o_regWrite), .o_misaligned(o_misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, mr, mw;
        logic [1:0]  width;
        logic        uns;
        logic [31:0] result, data;
        logic [4:0]  wreg;
        logic        m2r, rw;
        logic [7:0]  dbg;
        logic [31:0] e_read, e_result;
        logic [4:0]  e_wreg;
        logic        e_rw, e_mis;
        logic [31:0] e_dbg;
    } vec_t;

    vec_t tbl[13];

    // Reference model: flat byte array plus the expected registered outputs.
    logic [7:0]  mb [1024];
    logic [31:0] m_read, m_result;
    logic [4:0]  m_wreg;
    logic        m_m2r, m_rw, m_mis;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) mb[i] = 8'h00;
        m_read = 0; m_result = 0; m_wreg = 0; m_m2r = 0; m_rw = 0; m_mis = 0;
    endtask

    // Apply one clock edge to the model using the currently driven inputs.
    task automatic model_edge();
        int size, a;
        logic [31:0] ld;
        logic mis;
        size = (i_width == 2'b00) ? 1 : (i_width == 2'b01) ? 2 : 4;
        a    = int'(i_result[9:0]);
        mis  = (i_memRead || i_memWrite) && (a % size != 0);
        ld   = 0;
        if (i_memRead && !mis) begin
            for (int b = 0; b < size; b++) ld = ld | (32'(mb[a+b]) << (8*b));
            if (size < 4 && !i_unsigned && ld[8*size-1]) ld = ld | (32'hFFFF_FFFF << (8*size));
        end
        if (!i_stall && !i_halt) begin
            if (i_memWrite && !mis)
                for (int b = 0; b < size; b++) mb[a+b] = 8'(i_data2mem >> (8*b));
            m_read = ld; m_result = i_result; m_wreg = i_write_reg;
            m_m2r = i_mem2reg; m_rw = i_regWrite; m_mis = mis;
        end
    endtask

    function automatic logic [31:0] model_word(input logic [7:0] w);
        int base;
        base = 4 * int'(w);
        return {mb[base+3], mb[base+2], mb[base+1], mb[base]};
    endfunction

    task automatic idle();
        i_stall = 0; i_halt = 0; i_result = 0; i_data2mem = 0; i_write_reg = 0;
        i_mem2reg = 0; i_memRead = 0; i_memWrite = 0; i_regWrite = 0;
        i_width = 2'b11; i_unsigned = 0; i_dbg_addr = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_read"}, o_read_data, 0);
        check({tag, "_result"}, o_result, 0);
        check({tag, "_wreg"}, 32'(o_write_reg), 0);
        check({tag, "_ctl"}, {29'd0, o_mem2reg, o_regWrite, o_misaligned}, 0);
    endtask

    initial begin
        tbl[0]  = '{0,0,1,3,0,'h10,'hDEADBEEF,0,0,0,4, 0,'h10,0,0,0,'hDEADBEEF};
        tbl[1]  = '{0,1,0,3,0,'h10,0,5,1,1,4, 'hDEADBEEF,'h10,5,1,0,'hDEADBEEF};
        tbl[2]  = '{0,0,1,0,0,'h13,'h7F,0,0,0,4, 0,'h13,0,0,0,'h7FADBEEF};
        tbl[3]  = '{0,1,0,0,0,'h12,0,5,1,1,4, 'hFFFFFFAD,'h12,5,1,0,'h7FADBEEF};
        tbl[4]  = '{0,1,0,0,1,'h12,0,5,1,1,4, 'h000000AD,'h12,5,1,0,'h7FADBEEF};
        tbl[5]  = '{0,1,0,1,0,'h10,0,5,1,1,4, 'hFFFFBEEF,'h10,5,1,0,'h7FADBEEF};
        tbl[6]  = '{0,1,0,1,1,'h12,0,5,1,1,4, 'h00007FAD,'h12,5,1,0,'h7FADBEEF};
        tbl[7]  = '{0,0,1,3,0,'h21,'h12345678,0,0,0,8, 0,'h21,0,0,1,0};
        tbl[8]  = '{0,1,0,1,0,'h11,0,5,1,1,4, 0,'h11,5,1,1,'h7FADBEEF};
        tbl[9]  = '{1,0,1,3,0,'h8,'hAAAA5555,0,0,0,2, 0,'h11,5,1,1,0};
        tbl[10] = '{0,0,1,3,0,'h8,'hAAAA5555,0,0,0,2, 0,'h8,0,0,0,'hAAAA5555};
        tbl[11] = '{0,0,0,3,0,'h55,0,9,0,1,0, 0,'h55,9,1,0,0};
        tbl[12] = '{0,0,1,3,0,'h404,'h01020304,0,0,0,1, 0,'h404,0,0,0,'h01020304};

        idle();
        i_rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        for (int a = 0; a < 256; a++) begin
            i_dbg_addr = 8'(a);
            #0.1;
            check("reset_dbg", o_dbg_data, 0);
        end
        @(negedge clk);
        i_rst_n = 1;

        for (int i = 0; i < 13; i++) begin
            i_stall = tbl[i].stall; i_memRead = tbl[i].mr; i_memWrite = tbl[i].mw;
            i_width = tbl[i].width; i_unsigned = tbl[i].uns; i_result = tbl[i].result;
            i_data2mem = tbl[i].data; i_write_reg = tbl[i].wreg; i_mem2reg = tbl[i].m2r;
            i_regWrite = tbl[i].rw; i_dbg_addr = tbl[i].dbg;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_read", i), o_read_data, tbl[i].e_read);
            check($sformatf("vec%0d_result", i), o_result, tbl[i].e_result);
            check($sformatf("vec%0d_wreg", i), 32'(o_write_reg), 32'(tbl[i].e_wreg));
            check($sformatf("vec%0d_rw", i), 32'(o_regWrite), 32'(tbl[i].e_rw));
            check($sformatf("vec%0d_mis", i), 32'(o_misaligned), 32'(tbl[i].e_mis));
            check($sformatf("vec%0d_dbg", i), o_dbg_data, tbl[i].e_dbg);
        end

        // Store at word 0, then assert reset in the middle of a second store.
        idle();
        i_memWrite = 1; i_result = 0; i_data2mem = 32'h1111_1111;
        @(posedge clk);
        #1;
        check("pre_reset_store", o_dbg_data, 32'h1111_1111);
        i_data2mem = 32'hCAFE_F00D;
        @(negedge clk);
        i_rst_n = 0;
        #1;
        check_all_zero("async_reset");
        check("async_reset_dbg", o_dbg_data, 0);
        @(posedge clk);
        @(negedge clk);
        i_rst_n = 1;
        idle();
        i_dbg_addr = 8'd0;
        #1;
        check("reset_mid_store_dbg", o_dbg_data, 0);
        i_dbg_addr = 8'd1;
        #1;
        check("reset_cleared_word1", o_dbg_data, 0);
        model_reset();

        for (int n = 0; n < 400; n++) begin
            i_stall     = ($urandom_range(0, 7) == 0);
            i_halt      = ($urandom_range(0, 7) == 0);
            i_result    = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
            i_data2mem  = $urandom;
            i_write_reg = 5'($urandom);
            i_mem2reg   = 1'($urandom);
            i_regWrite  = 1'($urandom);
            i_memRead   = 1'($urandom);
            i_memWrite  = 1'($urandom);
            i_width     = 2'($urandom);
            i_unsigned  = 1'($urandom);
            i_dbg_addr  = 8'($urandom_range(0, 15));
            model_edge();
            @(posedge clk);
            #1;
            check("rnd_read", o_read_data, m_read);
            check("rnd_result", o_result, m_result);
            check("rnd_wreg", 32'(o_write_reg), 32'(m_wreg));
            check("rnd_ctl", {29'd0, o_mem2reg, o_regWrite, o_misaligned}, {29'd0, m_m2r, m_rw, m_mis});
            check("rnd_dbg", o_dbg_data, model_word(i_dbg_addr));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
